// File: rtl/relu_nn_ctrl.sv
// Inference sequencer for the 2-2-1 ReLU XOR network: accepts an input pair, holds it on
// the network inputs, waits LATENCY+1 edges, captures and thresholds the output, counts results.
module relu_nn_ctrl #(
  parameter int          WIDTH      = 16,
  parameter int          FRAC       = 8,
  parameter int          LATENCY    = 2,
  parameter int          THRESH     = 128,
  parameter logic [15:0] COUNT_INIT = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] nn_in1,
  output logic [WIDTH-1:0] nn_in2,
  input  logic [WIDTH-1:0] nn_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic             out_bit,
  output logic [15:0]      inf_count,
  output logic [1:0]       dbg_state
);

  // An out-of-range FRAC collapses the threshold to zero rather than wrapping it.
  localparam logic signed [WIDTH-1:0] THRESH_Q = (FRAC < WIDTH) ? WIDTH'(THRESH) : '0;
  localparam logic [3:0]              LAT      = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] cnt;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready/out_valid are registered alongside state, so neither depends on the peer's signal.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cnt       <= '0;
      nn_in1    <= '0;
      nn_in2    <= '0;
      out_value <= '0;
      out_bit   <= 1'b0;
      inf_count <= COUNT_INIT;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            nn_in1   <= in_a;
            nn_in2   <= in_b;
            cnt      <= '0;
            state    <= S_WAIT;
            in_ready <= 1'b0;
          end
        end
        S_WAIT: begin
          if (cnt == LAT) begin
            out_value <= nn_out;
            out_bit   <= ($signed(nn_out) >= THRESH_Q);
            state     <= S_DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            inf_count <= inf_count + 16'd1;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule
